serial_binary_to_bcd: RTL

Parametrised, clocked binary-to-BCD converter using the shift-and-add-3 (double-dabble) algorithm, one input bit per cycle. It generalises the 4-bit combinational converter in the display path to arbitrary input widths and digit counts. It adds a start/done handshake and an overflow flag for inputs that do not fit in the configured digit count. It sits between the code/counter datapath and the seven-segment decoders.

---
 rtl/serial_binary_to_bcd.sv | 118 +++++++++++
 1 files changed

// File: rtl/serial_binary_to_bcd.sv
// Serial binary-to-BCD converter using shift-and-add-3 (double dabble).
// It converts one input bit per clock and uses a start/done handshake.
// If the configured digit count is too small for the input value,
// the converter raises an overflow flag.
module serial_binary_to_bcd #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  overflow
);

  localparam int SW = 4 * DIGITS;
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t          state;
  state_t          state_next;
  logic [WIDTH-1:0] shreg;
  logic [SW-1:0]    scratch;
  logic [SW-1:0]    corrected;
  logic [SW-1:0]    shifted;
  logic             spill;
  logic             sticky;
  logic [CW-1:0]    cnt;
  logic             accept;
  logic             last;

  // A start request is only honoured when no conversion is running.
  assign accept = start && (state != SHIFT);
  assign last   = (state == SHIFT) && (cnt == LAST);

  // Add-3 correction on every digit that is 5 or more, all digits in parallel.
  always_comb begin
    // NOTE: assign a default to every always_comb output first, so that no path can infer a latch.
    corrected = scratch;
    for (int k = 0; k < DIGITS; k++) begin
      if (scratch[4*k +: 4] >= 4'd5) begin
        corrected[4*k +: 4] = scratch[4*k +: 4] + 4'd3;
      end
    end
  end

  // The corrected scratch shifts left. The next binary MSB enters at the
  // bottom, and the bit that leaves the top digit is the spill bit.
  assign spill   = corrected[SW-1];
  assign shifted = {corrected[SW-2:0], shreg[WIDTH-1]};

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state is assigned with non-blocking (<=), so every flop samples pre-edge values.
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic and status outputs, decoded from the registered state only.
  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) state_next = SHIFT;
      end
      SHIFT: begin
        busy = 1'b1;
        if (last) state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = start ? SHIFT : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath: load on accept, shift one bit per SHIFT cycle, publish on the last bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      shreg    <= '0;
      scratch  <= '0;
      sticky   <= 1'b0;
      cnt      <= '0;
      bcd      <= '0;
      overflow <= 1'b0;
    end else if (accept) begin
      shreg   <= bin;
      scratch <= '0;
      sticky  <= 1'b0;
      cnt     <= '0;
    end else if (state == SHIFT) begin
      shreg   <= shreg << 1;
      scratch <= shifted;
      sticky  <= sticky | spill;
      cnt     <= cnt + CW'(1);
      if (last) begin
        bcd      <= shifted;
        overflow <= sticky | spill;
      end
    end
  end

endmodule
